// File: rtl/aes_block_assembler.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_assembler
// Purpose  : Packs USB DATAx payload bytes, delivered one per enable_data
//            strobe from the PID decoder, into BLOCK_BYTES-wide AES input
//            blocks. Each completed block is handed to the AES core through a
//            valid/ready handshake. One block of buffering (assembly register
//            plus output holding register) lets reception continue while the
//            core is busy. A byte that arrives while both registers are full
//            is dropped and latches the sticky overrun flag.
// Build    : Define PKCS_PAD_EN to have flush PKCS#7-pad and emit the partial
//            block. Without it, flush discards the partial block.
// Ports    : clk          system clock
//            n_rst        asynchronous active-low reset
//            enable_data  one-cycle strobe, rcv_data holds a payload byte
//            rcv_data     received payload byte
//            flush        one-cycle end-of-stream strobe
//            block_ready  AES core accepts block_data this cycle
//            block_data   assembled block, first byte in the MSB byte lane
//            block_valid  block_data holds an unconsumed block
//            byte_count   bytes currently in the assembly register
//            overrun      sticky byte-dropped flag, cleared only by reset
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_assembler #(
  parameter int BLOCK_BYTES = 16,
  parameter int CNT_W       = 5
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     enable_data,
  input  logic [7:0]               rcv_data,
  input  logic                     flush,
  input  logic                     block_ready,
  output logic [8*BLOCK_BYTES-1:0] block_data,
  output logic                     block_valid,
  output logic [CNT_W-1:0]         byte_count,
  output logic                     overrun
);

  localparam int BW = 8 * BLOCK_BYTES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_BYTES);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    asm_q, asm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  // Working copies of the assembly register after this cycle's byte and
  // flush have been applied, before deciding where the result goes.
  logic [BW-1:0]    asm_tmp;
  logic [CNT_W-1:0] cnt_tmp;
  logic             complete;
  logic             out_free;
`ifdef PKCS_PAD_EN
  logic [7:0]       pad_byte;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= FILL;
      asm_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    asm_tmp  = asm_q;
    cnt_tmp  = cnt_q;
    complete = 1'b0;
`ifdef PKCS_PAD_EN
    pad_byte = 8'h00;
`endif

    // The output register can take a new block this edge if it is empty or
    // its current block is being accepted right now.
    out_free = !valid_q || block_ready;

    if (valid_q && block_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (enable_data) begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (CNT_W'(i) == cnt_q) begin
              asm_tmp[8*(BLOCK_BYTES-1-i) +: 8] = rcv_data;
            end
          end
          cnt_tmp = cnt_q + CNT_W'(1);
        end

        complete = (cnt_tmp == FULL_CNT);

        // Flush acts on the post-capture contents; a byte that completes
        // the block takes priority and flush then has nothing left to do.
        if (flush && !complete) begin
`ifdef PKCS_PAD_EN
          pad_byte = 8'(BLOCK_BYTES - int'(cnt_tmp));
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (CNT_W'(i) >= cnt_tmp) begin
              asm_tmp[8*(BLOCK_BYTES-1-i) +: 8] = pad_byte;
            end
          end
          complete = 1'b1;
`else
          asm_tmp = '0;
          cnt_tmp = '0;
`endif
        end

        if (complete) begin
          if (out_free) begin
            out_d   = asm_tmp;
            valid_d = 1'b1;
            asm_d   = '0;
            cnt_d   = '0;
          end else begin
            asm_d   = asm_tmp;
            cnt_d   = FULL_CNT;
            state_d = HOLD;
          end
        end else begin
          asm_d = asm_tmp;
          cnt_d = cnt_tmp;
        end
      end

      HOLD: begin
        // No room anywhere: the byte is lost, even on the exit edge.
        if (enable_data) begin
          ovr_d = 1'b1;
        end
        // block_valid is necessarily 1 here, so ready alone means transfer.
        if (block_ready) begin
          out_d   = asm_q;
          valid_d = 1'b1;
          asm_d   = '0;
          cnt_d   = '0;
          state_d = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign block_data  = out_q;
  assign block_valid = valid_q;
  assign byte_count  = cnt_q;
  assign overrun     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_block_assembler
// Purpose  : Directed, self-checking bench for aes_block_assembler. A table
//            of byte-run vectors covers the streaming behaviour with the AES
//            core always ready; hand-written sequences cover back-pressure,
//            HOLD, overrun and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_block_assembler;

  localparam int BB = 16;
  localparam int CW = 5;

  logic            clk;
  logic            n_rst;
  logic            enable_data;
  logic [7:0]      rcv_data;
  logic            flush;
  logic            block_ready;
  logic [8*BB-1:0] block_data;
  logic            block_valid;
  logic [CW-1:0]   byte_count;
  logic            overrun;

  int checks = 0;
  int errors = 0;

  aes_block_assembler #(.BLOCK_BYTES(BB), .CNT_W(CW)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable_data (enable_data),
    .rcv_data    (rcv_data),
    .flush       (flush),
    .block_ready (block_ready),
    .block_data  (block_data),
    .block_valid (block_valid),
    .byte_count  (byte_count),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] B00 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] B10 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] B20 = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] B30 = 128'h303132333435363738393A3B3C3D3E3F;
  localparam logic [127:0] B40 = 128'h404142434445464748494A4B4C4D4E4F;
  localparam logic [127:0] BC0 = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
  localparam logic [127:0] PAD_AA = 128'hAAAAAAAAAA0B0B0B0B0B0B0B0B0B0B0B;
  localparam logic [127:0] PAD_16 = 128'h10101010101010101010101010101010;
  localparam logic [127:0] PAD_13 = 128'h0102030405060708090A0B0C0D030303;

  // Mode-dependent expectations for flush of a partial block.
`ifdef PKCS_PAD_EN
  localparam logic PADV = 1'b1;
`else
  localparam logic PADV = 1'b0;
`endif

  typedef struct {
    string        name;
    int           n;          // number of byte strobes
    logic [7:0]   first;      // first byte value
    logic         inc;        // 1: bytes increment, 0: constant
    logic         fl_last;    // flush together with the last strobe
    logic         fl_after;   // separate flush cycle after the strobes
    logic [CW-1:0] exp_cnt;
    logic         exp_valid;
    logic [127:0] exp_data;   // checked only when exp_valid
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive one clock cycle worth of inputs; returns 1 time unit after the
  // active edge with the strobes already deasserted.
  task automatic step(input logic en, input logic [7:0] d, input logic fl,
                      input logic rdy);
    enable_data = en;
    rcv_data    = d;
    flush       = fl;
    block_ready = rdy;
    @(posedge clk);
    #1;
    enable_data = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic send_run(input int n, input logic [7:0] first,
                          input logic inc, input logic fl_last,
                          input logic rdy);
    logic [7:0] b;
    b = first;
    for (int k = 0; k < n; k++) begin
      step(1'b1, b, fl_last && (k == n - 1), rdy);
      if (inc) b = b + 8'd1;
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst       = 1'b0;
    enable_data = 1'b0;
    rcv_data    = 8'h00;
    flush       = 1'b0;
    block_ready = 1'b1;

    vecs[0] = '{"blk00",    16, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, B00};
    vecs[1] = '{"aa_flush",  5, 8'hAA, 1'b0, 1'b0, 1'b1, 5'd0, PADV, PAD_AA};
    vecs[2] = '{"blk20",    16, 8'h20, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, B20};
    vecs[3] = '{"blk30_fl", 16, 8'h30, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, B30};
    vecs[4] = '{"part7",     7, 8'h40, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 128'h0};
    vecs[5] = '{"rest9",     9, 8'h47, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, B40};
    vecs[6] = '{"flush0",    0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, PADV, PAD_16};
    vecs[7] = '{"pad13",    13, 8'h01, 1'b1, 1'b0, 1'b1, 5'd0, PADV, PAD_13};

    // Reset state
    #2;
    chk("rst_valid", 128'(block_valid), 128'd0);
    chk("rst_cnt",   128'(byte_count),  128'd0);
    chk("rst_data",  block_data,        128'd0);
    chk("rst_ovr",   128'(overrun),     128'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Streaming vectors, AES core always ready
    for (int v = 0; v < 8; v++) begin
      send_run(vecs[v].n, vecs[v].first, vecs[v].inc, vecs[v].fl_last, 1'b1);
      if (vecs[v].fl_after) step(1'b0, 8'h00, 1'b1, 1'b1);
      chk({vecs[v].name, "_cnt"},   128'(byte_count),  128'(vecs[v].exp_cnt));
      chk({vecs[v].name, "_valid"}, 128'(block_valid), 128'(vecs[v].exp_valid));
      if (vecs[v].exp_valid)
        chk({vecs[v].name, "_data"}, block_data, vecs[v].exp_data);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_valid", 128'(block_valid), 128'd0);

    // Back-pressure: two blocks with the core stalled
    do_reset();
    send_run(16, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bp1_valid", 128'(block_valid), 128'd1);
    chk("bp1_data",  block_data,        B00);
    chk("bp1_cnt",   128'(byte_count),  128'd0);
    send_run(16, 8'h10, 1'b1, 1'b0, 1'b0);
    chk("hold_cnt",  128'(byte_count),  128'd16);
    chk("hold_data", block_data,        B00);
    chk("hold_ovr",  128'(overrun),     128'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);          // flush in HOLD is ignored
    chk("hold_flush_cnt", 128'(byte_count), 128'd16);
    step(1'b1, 8'h99, 1'b0, 1'b0);          // 33rd strobe
    chk("ovr_set",   128'(overrun),     128'd1);
    chk("ovr_cnt",   128'(byte_count),  128'd16);
    chk("ovr_data",  block_data,        B00);
    step(1'b1, 8'h77, 1'b0, 1'b1);          // HOLD exit; this byte is lost
    chk("blk2_valid", 128'(block_valid), 128'd1);
    chk("blk2_data",  block_data,        B10);
    chk("blk2_cnt",   128'(byte_count),  128'd0);
    chk("blk2_ovr",   128'(overrun),     128'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("blk2_done",  128'(block_valid), 128'd0);

    // Async reset with a block pending and overrun set
    send_run(16, 8'h50, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_valid", 128'(block_valid), 128'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_valid", 128'(block_valid), 128'd0);
    chk("arst_data",  block_data,        128'd0);
    chk("arst_ovr",   128'(overrun),     128'd0);
    #3;
    n_rst = 1'b1;

    // Async reset mid-block at count 7
    @(posedge clk);
    #1;
    send_run(7, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("mid_cnt7", 128'(byte_count), 128'd7);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_cnt", 128'(byte_count), 128'd0);
    #3;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    send_run(1, 8'hC0, 1'b1, 1'b0, 1'b1);
    chk("after_rst_cnt1", 128'(byte_count), 128'd1);
    send_run(15, 8'hC1, 1'b1, 1'b0, 1'b1);
    chk("after_rst_valid", 128'(block_valid), 128'd1);
    chk("after_rst_data",  block_data,        BC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_block_assembler.md
Name: aes_block_assembler

Overview:
- Sits directly downstream of the USB PID decoder.
- Consumes the data-byte strobe and byte bus, which carry USB DATAx payload bytes, and packs consecutive payload bytes into 128-bit AES input blocks.
- Presents each completed block to the AES core over a valid/ready handshake, with one block of buffering so reception can continue while the core is busy.
- Detects and flags byte overrun; an optional mode pads and emits a partial block on flush.

Parameters:
BLOCK_BYTES, 16, number of bytes per output block; block width is 8*BLOCK_BYTES bits
CNT_W, 5, byte counter width; must satisfy 2^CNT_W > BLOCK_BYTES

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
enable_data  input  1  one-cycle strobe: rcv_data holds a payload byte to capture
rcv_data  input  8  received byte, valid when enable_data=1
flush  input  1  one-cycle end-of-stream strobe; ends the current partial block
block_ready  input  1  AES core accepts block_data this cycle when block_valid=1
block_data  output  8*BLOCK_BYTES  assembled block; first received byte in bits [8*BLOCK_BYTES-1 -: 8]
block_valid  output  1  block_data holds an unconsumed block
byte_count  output  CNT_W  bytes currently in the assembly register (0..BLOCK_BYTES)
overrun  output  1  sticky: a byte was dropped because both registers were full

Behaviour:
- Reset (async, n_rst=0): all of the following take effect immediately, including mid-block; any partial or held data is discarded.
  - byte_count=0, block_valid=0, block_data=0, overrun=0
  - assembly register=0; state=FILL
- Storage: an assembly register of BLOCK_BYTES bytes, plus an output holding register that drives block_data.
- Byte capture: on clk edge with enable_data=1 in state FILL, rcv_data is written to byte slot byte_count (slot 0 = MSB byte) and byte_count increments.
- Block completion: when the captured byte brings the count to BLOCK_BYTES, the block moves to the output register on the same edge if the output is free. "Free" means block_valid=0, or block_valid=1 and block_ready=1 in that cycle.
  - Output free: block_valid=1 next cycle and byte_count=0. Latency is 1 clk from the last byte strobe to block_valid.
  - Output not free: go to state HOLD with byte_count=BLOCK_BYTES.
- Handshake rules:
  - Transfer occurs when block_valid & block_ready on a clk edge.
  - block_data is stable while block_valid=1 and not yet accepted.
  - block_valid falls the cycle after acceptance, unless a new block is loaded on the same edge, in which case block_valid stays 1.
- State machine:
  - FILL: accepting bytes, as above.
  - HOLD: assembly register full, waiting for the output register.
    - When block_ready=1, the assembly contents move to the output register, block_valid stays 1, byte_count=0, and the state returns to FILL.
    - enable_data in HOLD drops the byte and sets overrun=1. This applies even in the cycle in which HOLD exits; that byte is still dropped.
- overrun clears only on reset.
- flush, without the optional feature:
  - The partial assembly is discarded: byte_count=0, assembly register cleared.
  - flush in HOLD has no effect; a full block is never discarded.
  - flush with byte_count=0 has no effect.
- enable_data and flush in the same cycle: the byte is captured first, then flush is applied to the result.
  - If that byte completes a block, the block is emitted normally and flush has no further effect.
- Bytes are counted across USB packet boundaries; only flush or reset terminates a block.

Optional Feature:
PKCS_PAD_EN
- Defined: flush in FILL with 0 < byte_count < BLOCK_BYTES pads the block.
  - The remaining slots are filled with the byte value (BLOCK_BYTES - byte_count), per PKCS#7.
  - The padded block is then treated as a completed block: it goes straight to the output if free, otherwise to HOLD.
  - flush with byte_count=0 emits a full pad block of BLOCK_BYTES bytes, each 8'h10 for 16.
- Undefined: flush discards the partial block as described in Behaviour; no pad logic is generated.

Test Plan:
- Reset then 16 strobes with bytes 00..0F, block_ready=1 -> block_valid=1 one clk after the 16th strobe; block_data=128'h000102030405060708090A0B0C0D0E0F; byte_count=0.
- Two blocks back to back (bytes 00..1F), block_ready=0 -> first block held stable, state HOLD, byte_count=16. 33rd strobe -> overrun=1. Raise block_ready -> second block (10..1F) appears with block_valid still 1.
- 5 bytes AA, then flush (feature off) -> byte_count=0, no block_valid. 16 more bytes -> normal block with no AA contamination.
- PKCS_PAD_EN defined: 13 bytes 01..0D then flush -> block_data=01..0D,03,03,03. Flush at count 0 -> 16 bytes of 8'h10.
- enable_data with byte 0F as the 16th byte together with flush -> normal full block emitted, no pad; byte_count=0.
- Assert n_rst low mid-block (count 7) and while block_valid=1 -> all outputs 0 immediately, including overrun. Next byte lands in slot 0.
